axi_mailbox: RTL and testbench
==============================

Name: axi_mailbox

Overview:
- AXI4 responder (subordinate) that exposes a memory-mapped FIFO mailbox for passing 8-bit messages between cores.
- Attaches to the same axi_if bus as axi_ram, at the far end from a CPU initiator (sr_cpu_axi). Writes to the DATA register push into the FIFO; reads from it pop.
- Provides STATUS/COUNT registers and a level interrupt. The write and read channels are served by independent FSMs.

Parameters:
- DATA_WIDTH, 8, AXI data width. Only 8 is supported.
- DEPTH, 16, FIFO entries. Must be a power of 2, range 2..128.
- ADDR_WIDTH, 32, AXI address width. Only addr[1:0] is decoded.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- axi_s  interface  axi_if (responder side)  AW/W/B/AR/R channels; ID widths come from the interface
- irq  output  1  high while FIFO count > 0

Behaviour:
Clock and reset:
- One clock; reset is asynchronous, active-low.
- Reset values: AWREADY=1, ARREADY=1, WREADY=0, BVALID=0, RVALID=0, RLAST=0, BRESP/RRESP=0, RDATA=0, irq=0.
- FIFO pointers and count reset to 0.
- Reset mid-transaction aborts both FSMs to IDLE and empties the FIFO. No B or R is issued for aborted bursts.

Register map (addr[1:0]):
- 0 DATA: W pushes, R pops.
- 1 STATUS: R only. bit0 = empty, bit1 = full, other bits 0.
- 2 COUNT: R only. Entry count zero-extended to 8 bits.
- 3: unmapped.

Bursts:
- The address is latched at AW/AR handshake and held constant for every beat, whatever the burst type or length.
- Beat count is AxLEN+1. AxSIZE is ignored.

Write FSM:
- W_IDLE: AWREADY=1. On AW handshake, latch AWID, offset and AWLEN, then go to W_DATA.
- W_DATA: WREADY=1.
  - Each W handshake pushes WDATA only if offset==0 and WSTRB[0]=1 and count<DEPTH.
  - An error flag is set on any beat where offset!=0, or where offset==0 and WSTRB[0]=1 and the FIFO is full. The data of such a beat is dropped.
  - Leave on the beat where the beat counter reaches AWLEN, independent of WLAST, and go to W_RESP.
- W_RESP: BVALID=1, BID = latched ID, BRESP = 2'b10 (SLVERR) if the error flag is set, else OKAY. On BREADY go to W_IDLE.

Read FSM:
- R_IDLE: ARREADY=1. On AR handshake, latch ARID, offset and ARLEN, then go to R_LOAD.
- R_LOAD: one cycle, RVALID=0. Form the beat into registers:
  - offset 0, FIFO not empty: RDATA = head, pop, OKAY.
  - offset 0, FIFO empty: RDATA = 0, SLVERR, no pop.
  - offset 1/2: snapshot of STATUS/COUNT, OKAY.
  - offset 3: RDATA = 0, SLVERR.
  - RLAST = (beat == ARLEN). Then go to R_DATA.
- R_DATA: RVALID=1. RDATA/RRESP/RID/RLAST stay stable until RREADY. On handshake go to R_IDLE if last, else R_LOAD.
- Latency: RVALID rises 2 cycles after the AR handshake. Throughput is 1 beat per 2 cycles.

Simultaneous events:
- A push and a pop in the same cycle leave count unchanged.
- Full/empty decisions use the count registered before that cycle. A push into a full FIFO is rejected even if a pop happens in the same cycle; a pop from an empty FIFO is rejected even if a push happens in the same cycle.
- AW and AR may be accepted in the same cycle.

FIFO:
- Pointers are log2(DEPTH) bits and wrap naturally.
- count is log2(DEPTH)+1 bits. irq = (count != 0), registered.

Decomposition:
- Package axi_mailbox_pkg holds:
  - offset localparams (OFS_DATA=0, OFS_STATUS=1, OFS_COUNT=2);
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - enum types wr_state_t {W_IDLE, W_DATA, W_RESP} and rd_state_t {R_IDLE, R_LOAD, R_DATA}.
- One sub-module, mailbox_fifo (push/pop/full/empty/count/head; rejects push when full and pop when empty). The AXI FSMs live in the top module.

Test Plan:
- Three single writes to 0x0 with 0xA1, 0xB2, 0xC3, AWID=5 -> three B beats with BID=5, OKAY. irq=1. Read of 0x2 returns 0x03.
- After that, a read burst on 0x0 with ARLEN=1, ARID=3 -> RDATA 0xA1 then 0xB2, RLAST on the 2nd beat, RID=3, OKAY. COUNT=1.
- Push 16 beats into an empty FIFO, then one write burst with AWLEN=1 -> BRESP SLVERR. STATUS=0x02, COUNT=0x10, FIFO contents unchanged.
- Empty FIFO, read of 0x0 -> RDATA 0x00, SLVERR. STATUS=0x01, irq=0.
- AW (write 0x5A to 0x0) and AR (read 0x2) handshaked in the same cycle on an empty FIFO, with RREADY held low 3 cycles -> RDATA 0x00 held stable, B OKAY, COUNT becomes 1.
- Assert rst_n low mid-burst (after 2 of 4 W beats) -> all VALIDs drop asynchronously, irq=0. A subsequent read of 0x2 returns 0x00.

Source files
------------

// File: rtl/axi_mailbox_pkg.sv
// Shared register offsets, response codes and FSM state types for the AXI mailbox.
package axi_mailbox_pkg;

    localparam logic [1:0] OFS_DATA   = 2'd0;
    localparam logic [1:0] OFS_STATUS = 2'd1;
    localparam logic [1:0] OFS_COUNT  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_DATA} rd_state_t;

endpackage

// File: rtl/axi_if.sv
// AXI4 bus bundle shared by initiators and responders; ID/address/data widths are set here.
interface axi_if #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport responder (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport initiator (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

endinterface

// File: rtl/mailbox_fifo.sv
// Circular FIFO for the mailbox; full/empty come from the registered count so
// a push into a full FIFO or a pop from an empty one is ignored even if the other side moves.
module mailbox_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned PtrWidth  = $clog2(DEPTH),
    localparam int unsigned CntWidth  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [CntWidth-1:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  nonempty
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0]   count_q, count_d;
    logic                  nonempty_q;
    logic                  do_push, do_pop;

    assign full    = (count_q == CntWidth'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_d = count_q + CntWidth'(do_push) - CntWidth'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            nonempty_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            // Tracks count_d so the flag always agrees with the count register.
            nonempty_q <= (count_d != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

    assign head     = mem[rd_ptr_q];
    assign count    = count_q;
    assign nonempty = nonempty_q;

endmodule

// File: rtl/axi_mailbox.sv
// AXI4 responder exposing an 8-bit FIFO mailbox: DATA (push/pop), STATUS and COUNT registers.
// Write and read channels run independent FSMs; irq is high while the FIFO holds data.
module axi_mailbox
    import axi_mailbox_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    axi_if.responder axi_s,
    output logic     irq
);
    localparam int unsigned IdWidth  = $bits(axi_s.awid);
    localparam int unsigned CntWidth = $clog2(DEPTH) + 1;

    if (DATA_WIDTH != 8) begin : g_bad_data_width
        $error("axi_mailbox: DATA_WIDTH must be 8");
    end
    if (DEPTH < 2 || DEPTH > 128 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("axi_mailbox: DEPTH must be a power of 2 in 2..128");
    end

    logic [DATA_WIDTH-1:0] fifo_head;
    logic [CntWidth-1:0]   fifo_count;
    logic                  fifo_full, fifo_empty;
    logic                  push, pop, w_hs, beat_err;

    // Write channel state
    wr_state_t           w_state_q;
    logic [IdWidth-1:0]  w_id_q;
    logic [1:0]          w_ofs_q;
    logic [7:0]          w_len_q, w_beat_q;
    logic                w_err_q, awready_q, wready_q, bvalid_q;
    logic [1:0]          bresp_q;

    // Read channel state
    rd_state_t             r_state_q;
    logic [IdWidth-1:0]    r_id_q;
    logic [1:0]            r_ofs_q;
    logic [7:0]            r_len_q, r_beat_q;
    logic                  arready_q, rvalid_q, rlast_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    assign w_hs     = axi_s.wvalid && wready_q;
    assign push     = w_hs && (w_ofs_q == OFS_DATA) && axi_s.wstrb[0];
    assign beat_err = w_hs && ((w_ofs_q != OFS_DATA) || (axi_s.wstrb[0] && fifo_full));
    assign pop      = (r_state_q == R_LOAD) && (r_ofs_q == OFS_DATA) && !fifo_empty;

    mailbox_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .wdata    (axi_s.wdata),
        .pop      (pop),
        .head     (fifo_head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .nonempty (irq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_ofs_q   <= '0;
            w_len_q   <= '0;
            w_beat_q  <= '0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            unique case (w_state_q)
                W_IDLE: begin
                    if (axi_s.awvalid && awready_q) begin
                        w_id_q    <= axi_s.awid;
                        w_ofs_q   <= axi_s.awaddr[1:0];
                        w_len_q   <= axi_s.awlen;
                        w_beat_q  <= '0;
                        w_err_q   <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        w_err_q <= w_err_q || beat_err;
                        // Burst length comes from AWLEN alone; WLAST is not consulted.
                        if (w_beat_q == w_len_q) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= (w_err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
                            w_state_q <= W_RESP;
                        end else begin
                            w_beat_q <= w_beat_q + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_s.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: begin
                    w_state_q <= W_IDLE;
                    awready_q <= 1'b1;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_ofs_q   <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            unique case (r_state_q)
                R_IDLE: begin
                    if (axi_s.arvalid && arready_q) begin
                        r_id_q    <= axi_s.arid;
                        r_ofs_q   <= axi_s.araddr[1:0];
                        r_len_q   <= axi_s.arlen;
                        r_beat_q  <= '0;
                        arready_q <= 1'b0;
                        r_state_q <= R_LOAD;
                    end
                end
                R_LOAD: begin
                    unique case (r_ofs_q)
                        OFS_DATA: begin
                            rdata_q <= fifo_empty ? '0 : fifo_head;
                            rresp_q <= fifo_empty ? RESP_SLVERR : RESP_OKAY;
                        end
                        OFS_STATUS: begin
                            rdata_q <= DATA_WIDTH'({fifo_full, fifo_empty});
                            rresp_q <= RESP_OKAY;
                        end
                        OFS_COUNT: begin
                            rdata_q <= DATA_WIDTH'(fifo_count);
                            rresp_q <= RESP_OKAY;
                        end
                        default: begin
                            rdata_q <= '0;
                            rresp_q <= RESP_SLVERR;
                        end
                    endcase
                    rlast_q   <= (r_beat_q == r_len_q);
                    rvalid_q  <= 1'b1;
                    r_state_q <= R_DATA;
                end
                R_DATA: begin
                    if (axi_s.rready) begin
                        rvalid_q <= 1'b0;
                        if (rlast_q) begin
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            r_beat_q  <= r_beat_q + 8'd1;
                            r_state_q <= R_LOAD;
                        end
                    end
                end
                default: begin
                    r_state_q <= R_IDLE;
                    arready_q <= 1'b1;
                    rvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign axi_s.awready = awready_q;
    assign axi_s.wready  = wready_q;
    assign axi_s.bvalid  = bvalid_q;
    assign axi_s.bid     = w_id_q;
    assign axi_s.bresp   = bresp_q;
    assign axi_s.arready = arready_q;
    assign axi_s.rvalid  = rvalid_q;
    assign axi_s.rid     = r_id_q;
    assign axi_s.rdata   = rdata_q;
    assign axi_s.rresp   = rresp_q;
    assign axi_s.rlast   = rlast_q;

    logic unused_sig;
    assign unused_sig = ^{axi_s.awaddr[ADDR_WIDTH-1:2], axi_s.araddr[ADDR_WIDTH-1:2],
                          axi_s.awsize, axi_s.awburst, axi_s.arsize, axi_s.arburst,
                          axi_s.wlast};

endmodule

// File: tb/tb_axi_mailbox.sv
// Randomized bench for axi_mailbox with a queue-based reference model of the mailbox registers.
module tb_axi_mailbox;
    import axi_mailbox_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic irq;

    always #5 clk = ~clk;

    axi_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(8)) bus ();

    axi_mailbox #(
        .DATA_WIDTH (8),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (32)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .axi_s (bus),
        .irq   (irq)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] model_q [$];
    logic [7:0] wbuf [256];
    logic       wstrb_buf [256];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_status();
        return {6'b0, model_q.size() == DEPTH, model_q.size() == 0};
    endfunction

    task automatic do_write(input logic [1:0] ofs, input logic [3:0] id, input int len,
                            input string tag);
        logic exp_err;
        int   t;
        exp_err = 1'b0;
        bus.awaddr       = $urandom();
        bus.awaddr[1:0]  = ofs;
        bus.awid         = id;
        bus.awlen        = 8'(len);
        bus.awsize       = 3'd0;
        bus.awburst      = 2'($urandom_range(0, 2));
        bus.awvalid      = 1'b1;
        t = 0;
        while (bus.awready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        check_eq({tag, "_awready"}, 32'(bus.awready), 1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            bus.wdata  = wbuf[i];
            bus.wstrb  = wstrb_buf[i];
            bus.wlast  = (i == len);
            bus.wvalid = 1'b1;
            t = 0;
            while (bus.wready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
            if (t >= 50) check_eq({tag, "_wready"}, 32'(bus.wready), 1);
            if (ofs != OFS_DATA) exp_err = 1'b1;
            else if (wstrb_buf[i]) begin
                if (model_q.size() < DEPTH) model_q.push_back(wbuf[i]);
                else exp_err = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.wvalid = 1'b0;
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin @(posedge clk); #1; end
        bus.bready = 1'b1;
        t = 0;
        while (bus.bvalid !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        check_eq({tag, "_bvalid"}, 32'(bus.bvalid), 1);
        check_eq({tag, "_bid"}, 32'(bus.bid), 32'(id));
        check_eq({tag, "_bresp"}, 32'(bus.bresp), exp_err ? 32'(RESP_SLVERR) : 32'(RESP_OKAY));
        @(posedge clk); #1;
        bus.bready = 1'b0;
        check_eq({tag, "_irq"}, 32'(irq), 32'(model_q.size() != 0));
    endtask

    task automatic do_read(input logic [1:0] ofs, input logic [3:0] id, input int len,
                           input string tag);
        logic [7:0] exp_data;
        logic [1:0] exp_resp;
        int         t;
        bus.araddr      = $urandom();
        bus.araddr[1:0] = ofs;
        bus.arid        = id;
        bus.arlen       = 8'(len);
        bus.arsize      = 3'd0;
        bus.arburst     = 2'($urandom_range(0, 2));
        bus.arvalid     = 1'b1;
        t = 0;
        while (bus.arready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        check_eq({tag, "_arready"}, 32'(bus.arready), 1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            // One load cycle with RVALID low, then the beat is presented.
            check_eq({tag, "_load"}, 32'(bus.rvalid), 0);
            @(posedge clk); #1;
            check_eq({tag, "_rvalid"}, 32'(bus.rvalid), 1);
            exp_resp = RESP_OKAY;
            case (ofs)
                OFS_DATA: begin
                    if (model_q.size() > 0) exp_data = model_q.pop_front();
                    else begin
                        exp_data = 8'h00;
                        exp_resp = RESP_SLVERR;
                    end
                end
                OFS_STATUS: exp_data = model_status();
                OFS_COUNT:  exp_data = 8'(model_q.size());
                default: begin
                    exp_data = 8'h00;
                    exp_resp = RESP_SLVERR;
                end
            endcase
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin @(posedge clk); #1; end
            bus.rready = 1'b1;
            check_eq({tag, "_rdata"}, 32'(bus.rdata), 32'(exp_data));
            check_eq({tag, "_rresp"}, 32'(bus.rresp), 32'(exp_resp));
            check_eq({tag, "_rid"}, 32'(bus.rid), 32'(id));
            check_eq({tag, "_rlast"}, 32'(bus.rlast), 32'(i == len));
            @(posedge clk); #1;
            bus.rready = 1'b0;
        end
        check_eq({tag, "_irq"}, 32'(irq), 32'(model_q.size() != 0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        bus.awid    = '0;  bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;  bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready  = 1'b0;
        bus.arid    = '0;  bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'({bus.awready, bus.arready, bus.wready}), 32'b110);
        check_eq("rst_valid", 32'({bus.bvalid, bus.rvalid, bus.rlast}), 0);
        check_eq("rst_resp", 32'({bus.bresp, bus.rresp}), 0);
        check_eq("rst_rdata", 32'(bus.rdata), 0);
        check_eq("rst_irq", 32'(irq), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Three single writes then COUNT.
        wstrb_buf[0] = 1'b1;
        wbuf[0] = 8'hA1; do_write(2'd0, 4'd5, 0, "w_a1");
        wbuf[0] = 8'hB2; do_write(2'd0, 4'd5, 0, "w_b2");
        wbuf[0] = 8'hC3; do_write(2'd0, 4'd5, 0, "w_c3");
        check_eq("irq_after_3", 32'(irq), 1);
        do_read(2'd2, 4'd1, 0, "count3");

        // Two-beat pop burst, then COUNT.
        do_read(2'd0, 4'd3, 1, "pop2");
        do_read(2'd2, 4'd1, 0, "count1");

        // Drain, fill to DEPTH, overflow burst, then verify contents.
        while (model_q.size() > 0) do_read(2'd0, 4'd2, model_q.size() - 1, "drain");
        for (int i = 0; i < 16; i++) begin
            wbuf[i]      = 8'($urandom());
            wstrb_buf[i] = 1'b1;
        end
        do_write(2'd0, 4'd4, 15, "fill");
        do_write(2'd0, 4'd4, 1, "overflow");
        do_read(2'd1, 4'd6, 0, "status_full");
        do_read(2'd2, 4'd6, 0, "count_full");
        do_read(2'd0, 4'd6, 15, "contents");

        // Empty-FIFO pop and STATUS.
        do_read(2'd0, 4'd8, 0, "pop_empty");
        do_read(2'd1, 4'd8, 0, "status_empty");
        check_eq("irq_empty", 32'(irq), 0);

        // AW and AR accepted in the same cycle; R held with RREADY low.
        bus.awaddr = 32'h0; bus.awid = 4'd7; bus.awlen = 8'd0; bus.awvalid = 1'b1;
        bus.araddr = 32'h2; bus.arid = 4'd9; bus.arlen = 8'd0; bus.arvalid = 1'b1;
        bus.wdata = 8'h5A; bus.wstrb = 1'b1; bus.wlast = 1'b1; bus.wvalid = 1'b1;
        check_eq("dual_ready", 32'({bus.awready, bus.arready}), 32'b11);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        bus.arvalid = 1'b0;
        check_eq("dual_wready", 32'(bus.wready), 1);
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        model_q.push_back(8'h5A);
        for (int k = 0; k < 3; k++) begin
            check_eq("dual_hold_valid", 32'(bus.rvalid), 1);
            check_eq("dual_hold_rdata", 32'(bus.rdata), 0);
            check_eq("dual_hold_rresp", 32'(bus.rresp), 32'(RESP_OKAY));
            @(posedge clk); #1;
        end
        check_eq("dual_rid", 32'(bus.rid), 9);
        check_eq("dual_rlast", 32'(bus.rlast), 1);
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
        check_eq("dual_bvalid", 32'(bus.bvalid), 1);
        check_eq("dual_bresp", 32'(bus.bresp), 32'(RESP_OKAY));
        check_eq("dual_bid", 32'(bus.bid), 7);
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        do_read(2'd2, 4'd9, 0, "dual_count");

        // Reset in the middle of a write burst with an R beat pending.
        check_eq("pre_rst_irq", 32'(irq), 1);
        bus.araddr = 32'h2; bus.arlen = 8'd0; bus.arvalid = 1'b1;
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        @(posedge clk); #1;
        check_eq("pre_rst_rvalid", 32'(bus.rvalid), 1);
        bus.awaddr = 32'h0; bus.awlen = 8'd3; bus.awvalid = 1'b1;
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.wdata = 8'(8'h10 + i); bus.wstrb = 1'b1; bus.wlast = 1'b0; bus.wvalid = 1'b1;
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 32'({bus.bvalid, bus.rvalid, bus.wready}), 0);
        check_eq("async_rst_ready", 32'({bus.awready, bus.arready}), 32'b11);
        check_eq("async_rst_irq", 32'(irq), 0);
        bus.wvalid = 1'b0;
        model_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_read(2'd2, 4'd1, 0, "post_rst_count");

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            logic [1:0] ofs;
            int         len;
            ofs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : OFS_DATA;
            len = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i <= len; i++) begin
                    wbuf[i]      = 8'($urandom());
                    wstrb_buf[i] = ($urandom_range(0, 4) != 0);
                end
                do_write(ofs, 4'($urandom()), len, "rnd_wr");
            end else begin
                do_read(ofs, 4'($urandom()), len, "rnd_rd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
